// File: rtl/histogram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : histogram_pkg
// Description : Shared types and helpers for the multi-channel histogram
//               generator: controller state encoding, channel-field width
//               calculation and {channel, pixel} RAM address packing.
// Revision    : 1.0 - initial release
// ============================================================================
package histogram_pkg;

  // Controller states (explicit 3-bit encoding).
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Width of the channel field of a bin address; a single channel still
  // occupies one address bit so the address layout stays uniform.
  function automatic int calc_ch_w(input int channels);
    int w;
    w = $clog2(channels);
    return (w < 1) ? 1 : w;
  endfunction

  // Bin address {channel, pixel}; the caller truncates to its address width.
  function automatic logic [31:0] pack_addr(input logic [31:0] channel,
                                            input logic [31:0] pixel,
                                            input int          pixel_width);
    return (channel << pixel_width) | pixel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/histogram_rmw_pipe.sv
`default_nettype none
// ============================================================================
// Module      : histogram_rmw_pipe
// Description : Read-modify-write stage for the histogram RAM. Registers each
//               issued read address, and in the following cycle (when the RAM
//               read data is valid) writes value+1 back to the same bin.
//               Back-to-back hits on one bin take the just-written value
//               instead of the stale RAM read data.
//               Optional macro: HISTOGRAM_SATURATE_EN (bins saturate at
//               all-ones instead of wrapping to zero).
// Ports       : clk, rst (async, active-low)
//               rd_en / rd_addr   - read being issued this cycle
//               rd_data           - RAM data for last cycle's read
//               wr_en / wr_addr / wr_data - RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_rmw_pipe
  import histogram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  // Read issued last cycle, whose data is on rd_data now.
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  // Write performed last cycle; not yet visible through the RAM read port.
  logic              last_valid;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  logic              fwd;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] incr;

  always_comb begin
    fwd  = pend_valid && last_valid && (pend_addr == last_addr);
    base = fwd ? last_data : rd_data;
`ifdef HISTOGRAM_SATURATE_EN
    incr = (&base) ? base : base + DATA_W'(1);
`else
    incr = base + DATA_W'(1);
`endif
  end

  assign wr_en   = pend_valid;
  assign wr_addr = pend_valid ? pend_addr : '0;
  assign wr_data = pend_valid ? incr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      last_valid <= 1'b0;
      last_addr  <= '0;
      last_data  <= '0;
    end else begin
      pend_valid <= rd_en;
      pend_addr  <= rd_addr;
      last_valid <= pend_valid;
      last_addr  <= pend_addr;
      last_data  <= incr;
    end
  end

endmodule
`default_nettype wire

// File: rtl/histogram_generator_mc.sv
`default_nettype none
// ============================================================================
// Module      : histogram_generator_mc
// Description : Multi-channel pipelined histogram accumulator. Latches one
//               table of CHANNELS x TABLE_SIZE pixels on start, optionally
//               clears every bin first, then bins one pixel per cycle into an
//               external simple-dual-port RAM via read-modify-write.
//               Optional macro: HISTOGRAM_SATURATE_EN (saturating bins).
// Ports       : clk, rst (async, active-low)
//               start, is_first_table, image_table - table input
//               ram_rd_en, ram_rd_addr, ram_rd_data - RAM read port
//               ram_wr_en, ram_wr_addr, ram_wr_data - RAM write port
//               busy, done - status
// Revision    : 1.0 - initial release
// ============================================================================
module histogram_generator_mc
  import histogram_pkg::*;
#(
  parameter int IMAGE_WIDTH                 = 320,
  parameter int IMAGE_HEIGHT                = 240,
  parameter int PIXEL_WIDTH                 = 8,
  parameter int TABLE_SIZE                  = 64,
  parameter int CHANNELS                    = 3,
  parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH + calc_ch_w(CHANNELS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   is_first_table,
  input  logic [CHANNELS*TABLE_SIZE*PIXEL_WIDTH-1:0] image_table,
  output logic                                   ram_rd_en,
  output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] ram_rd_addr,
  input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    ram_rd_data,
  output logic                                   ram_wr_en,
  output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] ram_wr_addr,
  output logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    ram_wr_data,
  output logic                                   busy,
  output logic                                   done
);

  localparam int AW        = HISTOGRAM_RAM_ADDRESS_WIDTH;
  localparam int DW        = HISTOGRAM_RAM_DATA_WIDTH;
  localparam int CH_W      = calc_ch_w(CHANNELS);
  localparam int TBL_W     = CHANNELS * TABLE_SIZE * PIXEL_WIDTH;
  localparam int TBL_IDX_W = (TBL_W > 1) ? $clog2(TBL_W) : 1;
  localparam int N_READS   = CHANNELS * TABLE_SIZE;
  localparam int N_CLEAR   = CHANNELS * (2 ** PIXEL_WIDTH);
  localparam int CNT_MAX   = (N_CLEAR > N_READS) ? N_CLEAR : N_READS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int PX_W      = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(N_CLEAR - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(N_READS - 1);
  localparam logic [PX_W-1:0]  PX_LAST    = PX_W'(TABLE_SIZE - 1);

  state_t state;
  state_t next_state;

  // cnt is the clear address in CLEAR and the flat (channel-major) pixel
  // index in COUNT; ch_cnt/px_cnt track the same pixel split by channel.
  logic [CNT_W-1:0]     cnt;
  logic [CH_W-1:0]      ch_cnt;
  logic [PX_W-1:0]      px_cnt;
  logic [TBL_W-1:0]     table_q;
  logic [TBL_IDX_W-1:0] bit_base;
  logic [PIXEL_WIDTH-1:0] pixel;

  logic          pipe_wr_en;
  logic [AW-1:0] pipe_wr_addr;
  logic [DW-1:0] pipe_wr_data;

  // Channel-major flat index maps directly onto the packed table layout.
  assign bit_base = TBL_IDX_W'(cnt) * TBL_IDX_W'(PIXEL_WIDTH);
  assign pixel    = table_q[bit_base +: PIXEL_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      ch_cnt  <= '0;
      px_cnt  <= '0;
      table_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            table_q <= image_table;
            cnt     <= '0;
            ch_cnt  <= '0;
            px_cnt  <= '0;
          end
        end
        ST_CLEAR: begin
          cnt <= (cnt == CLEAR_LAST) ? '0 : cnt + 1'b1;
        end
        ST_COUNT: begin
          cnt <= cnt + 1'b1;
          if (px_cnt == PX_LAST) begin
            px_cnt <= '0;
            ch_cnt <= ch_cnt + 1'b1;
          end else begin
            px_cnt <= px_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_rd_en   = 1'b0;
    ram_rd_addr = '0;
    ram_wr_en   = pipe_wr_en;
    ram_wr_addr = pipe_wr_addr;
    ram_wr_data = pipe_wr_data;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = is_first_table ? ST_CLEAR : ST_COUNT;
        end
      end
      ST_CLEAR: begin
        // The RMW pipe is idle here, so the write port is free for clears.
        busy        = 1'b1;
        ram_wr_en   = 1'b1;
        ram_wr_addr = AW'(cnt);
        ram_wr_data = '0;
        if (cnt == CLEAR_LAST) begin
          next_state = ST_COUNT;
        end
      end
      ST_COUNT: begin
        busy        = 1'b1;
        ram_rd_en   = 1'b1;
        ram_rd_addr = AW'(pack_addr(32'(ch_cnt), 32'(pixel), PIXEL_WIDTH));
        if (cnt == READ_LAST) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy       = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  histogram_rmw_pipe #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_rmw_pipe (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data),
    .wr_en   (pipe_wr_en),
    .wr_addr (pipe_wr_addr),
    .wr_data (pipe_wr_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_histogram_generator_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_histogram_generator_mc
// Description : Self-checking bench for histogram_generator_mc with a
//               behavioural RAM and a bin-count reference model.
//               Honours HISTOGRAM_SATURATE_EN when computing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_histogram_generator_mc;

  localparam int PW    = 8;
  localparam int TS    = 64;
  localparam int CH    = 3;
  localparam int DW    = 17;
  localparam int AW    = 10;
  localparam int N     = CH * TS;
  localparam int NBINS = CH * 256;
  localparam int TBL_W = CH * TS * PW;
  localparam int MAXI  = (1 << DW) - 1;

  localparam int PAT_RAMP  = 0;
  localparam int PAT_CONST = 1;
  localparam int PAT_RAND  = 2;
  localparam int PAT_RUNS  = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             is_first_table = 1'b0;
  logic [TBL_W-1:0] image_table = '0;
  logic             ram_rd_en;
  logic [AW-1:0]    ram_rd_addr;
  logic [DW-1:0]    ram_rd_data = '0;
  logic             ram_wr_en;
  logic [AW-1:0]    ram_wr_addr;
  logic [DW-1:0]    ram_wr_data;
  logic             busy;
  logic             done;

  histogram_generator_mc dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .is_first_table (is_first_table),
    .image_table    (image_table),
    .ram_rd_en      (ram_rd_en),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rd_data    (ram_rd_data),
    .ram_wr_en      (ram_wr_en),
    .ram_wr_addr    (ram_wr_addr),
    .ram_wr_data    (ram_wr_data),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Simple-dual-port RAM, read-before-write, with a bench preload port.
  logic [DW-1:0] mem [1024];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int          ref_bins [1024];
  logic [PW-1:0] tbl [N];

  typedef struct {
    bit first;
    int pat;
    int poke;
    int exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [TBL_W-1:0] pack_tbl();
    logic [TBL_W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = tbl[i];
    return v;
  endfunction

  task automatic fill_tbl(input int pat);
    int cur;
    cur = 0;
    for (int i = 0; i < N; i++) begin
      case (pat)
        PAT_RAMP:  tbl[i] = PW'(i % TS);
        PAT_CONST: tbl[i] = 8'd5;
        PAT_RAND:  tbl[i] = PW'($urandom);
        default: begin
          if (i == 0 || $urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 7));
          tbl[i] = PW'(cur);
        end
      endcase
    end
  endtask

  // Reference: histogram of the table, bin index = channel*256 + pixel value.
  task automatic model_apply(input bit first);
    int b;
    if (first) for (int k = 0; k < NBINS; k++) ref_bins[k] = 0;
    for (int i = 0; i < N; i++) begin
      b = (i / TS) * 256 + int'(tbl[i]);
`ifdef HISTOGRAM_SATURATE_EN
      if (ref_bins[b] < MAXI) ref_bins[b] = ref_bins[b] + 1;
`else
      ref_bins[b] = (ref_bins[b] + 1) % (MAXI + 1);
`endif
    end
  endtask

  task automatic compare_bins(input string name);
    int nb;
    int first_bad;
    nb = 0;
    first_bad = -1;
    for (int k = 0; k < NBINS; k++) begin
      if (mem[k] !== DW'(ref_bins[k])) begin
        nb++;
        if (first_bad < 0) first_bad = k;
      end
    end
    check({name, " bins differing"}, 64'(nb), 64'd0);
    if (first_bad >= 0)
      $display("  first differing bin %0d: ram %0d model %0d", first_bad, mem[first_bad], ref_bins[first_bad]);
  endtask

  task automatic preload(input int addr, input int val);
    pre_en   = 1'b1;
    pre_addr = AW'(addr);
    pre_data = DW'(val);
    ref_bins[addr] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Call at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_table(input bit first, input int poke, input int exp_done, input string name);
    int cyc, cexp, first_rd, last_rd, n_rd, n_wpre, n_nz, n_abad, n_wpost, n_ovl, n_busy, done_cyc;
    logic [TBL_W-1:0] img;
    cexp = first ? NBINS : 0;
    img = pack_tbl();
    image_table = img;
    is_first_table = first;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; first_rd = -1; last_rd = -1; n_rd = 0; n_wpre = 0; n_nz = 0; n_abad = 0;
    n_wpost = 0; n_ovl = 0; n_busy = 0; done_cyc = -1;
    while (cyc <= 1500) begin
      if (busy) n_busy++;
      if (ram_rd_en && ram_wr_en) n_ovl++;
      if (ram_rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        n_rd++;
      end
      if (ram_wr_en) begin
        if (first_rd < 0) begin
          n_wpre++;
          if (ram_wr_data != '0) n_nz++;
          if (ram_wr_addr != AW'(cyc - 1)) n_abad++;
        end else begin
          n_wpost++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      start = 1'b0;
      if (cyc == poke) begin
        start = 1'b1;
        is_first_table = ~first;
        image_table = ~img;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    image_table = img;
    check({name, " done cycle"}, 64'(done_cyc), 64'(exp_done));
    check({name, " first read cycle"}, 64'(first_rd), 64'(cexp + 1));
    check({name, " last read cycle"}, 64'(last_rd), 64'(cexp + N));
    check({name, " read count"}, 64'(n_rd), 64'(N));
    check({name, " clear writes"}, 64'(n_wpre), 64'(cexp));
    check({name, " clear nonzero data"}, 64'(n_nz), 64'd0);
    check({name, " clear addr order"}, 64'(n_abad), 64'd0);
    check({name, " rmw writes"}, 64'(n_wpost), 64'(N));
    check({name, " rd/wr overlap"}, 64'(n_ovl), 64'(N - 1));
    check({name, " busy cycles"}, 64'(n_busy), 64'(exp_done - 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset ram_rd_en", 64'(ram_rd_en), 64'd0);
    check("reset ram_wr_en", 64'(ram_wr_en), 64'd0);
    check("reset ram_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("reset ram_wr_addr", 64'(ram_wr_addr), 64'd0);
    check("reset ram_wr_data", 64'(ram_wr_data), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{1'b1, PAT_RAMP,  0,   962};
    vecs[1] = '{1'b0, PAT_RAMP,  0,   194};
    vecs[2] = '{1'b1, PAT_CONST, 0,   962};
    vecs[3] = '{1'b0, PAT_RAND,  0,   194};
    vecs[4] = '{1'b0, PAT_RUNS,  50,  194};
    vecs[5] = '{1'b1, PAT_RUNS,  300, 962};
    vecs[6] = '{1'b0, PAT_RAND,  0,   194};

    for (int v = 0; v < 7; v++) begin
      fill_tbl(vecs[v].pat);
      run_table(vecs[v].first, vecs[v].poke, vecs[v].exp_done, $sformatf("vec%0d", v));
      model_apply(vecs[v].first);
      @(negedge clk);  // cycle after done: DUT back in IDLE
      check($sformatf("vec%0d busy after done", v), 64'(busy), 64'd0);
      compare_bins($sformatf("vec%0d", v));
      if (v == 0) begin
        check("ramp bin {1,10}", 64'(mem[256+10]), 64'd1);
        check("ramp bin {2,200}", 64'(mem[512+200]), 64'd0);
      end
      if (v == 1) check("ramp x2 bin {2,63}", 64'(mem[512+63]), 64'd2);
      if (v == 2) begin
        check("const5 bin {0,5}", 64'(mem[5]), 64'd64);
        check("const5 bin {1,5}", 64'(mem[256+5]), 64'd64);
        check("const5 bin {2,5}", 64'(mem[512+5]), 64'd64);
        check("const5 bin {0,6}", 64'(mem[6]), 64'd0);
      end
    end

    // Saturation/wrap: single hit on a full bin, and a forwarded pair on another.
    preload(7, MAXI);
    preload(256 + 3, MAXI);
    for (int i = 0; i < N; i++) tbl[i] = 8'd9;
    tbl[0]  = 8'd7;
    tbl[64] = 8'd3;
    tbl[65] = 8'd3;
    run_table(1'b0, 0, 194, "sat");
    model_apply(1'b0);
    @(negedge clk);
    compare_bins("sat");
`ifdef HISTOGRAM_SATURATE_EN
    check("sat single hit", 64'(mem[7]), 64'(MAXI));
    check("sat forwarded pair", 64'(mem[256+3]), 64'(MAXI));
`else
    check("wrap single hit", 64'(mem[7]), 64'd0);
    check("wrap forwarded pair", 64'(mem[256+3]), 64'd1);
`endif

    // Reset in the middle of a clearing table.
    fill_tbl(PAT_RAMP);
    image_table = pack_tbl();
    is_first_table = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    check("pre-reset clearing busy", 64'(busy), 64'd1);
    check("pre-reset clearing wr_en", 64'(ram_wr_en), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset ram_wr_en", 64'(ram_wr_en), 64'd0);
    check("async reset ram_wr_addr", 64'(ram_wr_addr), 64'd0);
    check("async reset ram_rd_en", 64'(ram_rd_en), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    fill_tbl(PAT_RAND);
    run_table(1'b1, 0, 962, "post-reset");
    model_apply(1'b1);
    @(negedge clk);
    compare_bins("post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/histogram_generator_mc.md
# histogram_generator_mc

Multi-channel, pipelined histogram accumulator for decoded image tables. Each accepted table of CHANNELS × TABLE_SIZE pixels is binned into an external simple-dual-port histogram RAM at one pixel per cycle, using read-modify-write with same-address forwarding. The block sits after the colour-conversion stage. It optionally clears the histogram at the start of a frame, and replaces the single-channel, tristate-bus histogram generator.

## Interface
- IMAGE_WIDTH, 320, frame width in pixels
- IMAGE_HEIGHT, 240, frame height in pixels
- PIXEL_WIDTH, 8, bits per pixel sample; bins per channel = 2^PIXEL_WIDTH
- TABLE_SIZE, 64, pixels per channel per table
- CHANNELS, 3, colour channels per table (≥1)
- HISTOGRAM_RAM_DATA_WIDTH, 17, bin counter width, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
- HISTOGRAM_RAM_ADDRESS_WIDTH, PIXEL_WIDTH+CH_W, with CH_W = max(1,$clog2(CHANNELS))
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  table-valid strobe, sampled only in IDLE
- is_first_table  input  1  sampled with start; 1 = clear all bins first
- image_table  input  CHANNELS*TABLE_SIZE*PIXEL_WIDTH  channel c occupies bits [(c+1)*TABLE_SIZE*PIXEL_WIDTH-1 : c*TABLE_SIZE*PIXEL_WIDTH]; pixel 0 in the LSBs of each slice
- ram_rd_en  output  1  read request
- ram_rd_addr  output  HISTOGRAM_RAM_ADDRESS_WIDTH  read address {channel, pixel}
- ram_rd_data  input  HISTOGRAM_RAM_DATA_WIDTH  read data, valid one cycle after ram_rd_en
- ram_wr_en  output  1  write strobe
- ram_wr_addr  output  HISTOGRAM_RAM_ADDRESS_WIDTH  write address
- ram_wr_data  output  HISTOGRAM_RAM_DATA_WIDTH  write data
- busy  output  1  high from the first cycle after an accepted start until done
- done  output  1  single-cycle completion pulse

## Operation
- States: IDLE, CLEAR, COUNT, DRAIN, DONE.
- IDLE → (start) latch image_table and is_first_table. Go to CLEAR if is_first_table=1, otherwise to COUNT.
- CLEAR: write 0 to addresses 0 … CHANNELS·2^PIXEL_WIDTH−1 (channel-major), one per cycle, then go to COUNT.
- COUNT: issue reads for pixels in order: channel 0 pixel 0 … channel CHANNELS−1 pixel TABLE_SIZE−1. N = CHANNELS·TABLE_SIZE reads, then go to DRAIN.
- Each read is followed next cycle by a write to the same address of value+1.
- Forwarding: if read i+1 has the same address as read i, the increment uses the value written for pixel i, not ram_rd_data. Results must be exact for any run of repeated pixels.
- DRAIN: final write, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Arithmetic: increment is modulo 2^HISTOGRAM_RAM_DATA_WIDTH unless saturation is compiled in (see Configuration).
- start outside IDLE is ignored. A new start may arrive in the cycle after done.
- Reset (any time, including mid-table): all outputs 0, state IDLE, latched table discarded. RAM contents are undefined thereafter.

## Timing
- Reset values: ram_rd_en, ram_wr_en, ram_rd_addr, ram_wr_addr, ram_wr_data, busy and done are all 0.
- start sampled at edge 0. With C = CHANNELS·2^PIXEL_WIDTH when clearing (else C = 0):
  - Clear writes occupy cycles 1..C.
  - Reads occupy cycles C+1..C+N.
  - Writes occupy cycles C+2..C+N+1.
  - done is high in cycle C+N+2.
- Throughput: one pixel per cycle; no stalls.
- ram_rd_en and ram_wr_en are never asserted in CLEAR at the same time.

## Configuration
- HISTOGRAM_SATURATE_EN defined: a bin at all-ones stays at all-ones when incremented. Forwarded values saturate identically.
- HISTOGRAM_SATURATE_EN undefined: bins wrap to 0.

## Structure
- Package histogram_pkg holds:
  - state enum
  - CH_W calculation function
  - address-packing function {channel, pixel}
- Sub-module histogram_rmw_pipe holds:
  - read-address register
  - forwarding compare
  - incrementer (with saturation option)
  - write-port registers

## Test plan
- Reset, start=1, is_first_table=1, CHANNELS=3, pixel p of every channel = p:
  - cycles 1..768 write 0.
  - done at cycle 962.
  - bins {c, 0..63} = 1; all other bins = 0.
- Second table, is_first_table=0, same data → those bins = 2, done at cycle 194, no clear writes.
- All 192 pixels = 8'd5, RAM pre-cleared → bins {0,5}, {1,5}, {2,5} each = 64, proving forwarding on back-to-back hits.
- Bin preloaded to 2^17−1, one hit:
  - with HISTOGRAM_SATURATE_EN, result 2^17−1.
  - without it, result 0.
- Reset asserted at cycle 100 of a clearing table → all outputs 0 asynchronously. A start at the next edge after release is accepted and completes normally.
- start pulsed while busy → ignored: timing and bin results match a single-start run.
